// File: rtl/srl_test_sequencer_pkg.sv
// Shared FSM state type and helpers for the SRL init-test sequencer.
package srl_test_pkg;

  localparam int unsigned MAX_UNITS = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_WARM,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic int unsigned popcount(input logic [MAX_UNITS-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MAX_UNITS; i++) n = n + 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/srl_test_sequencer_ce_prescaler.sv
// Clock-enable prescaler: strobes on the first enabled cycle after clr,
// then once every CE_DIV enabled cycles.
module ce_prescaler #(
  parameter int unsigned CE_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic strobe
);

  localparam int unsigned DIV_W = $clog2(CE_DIV + 1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] phase;

  // clr forces phase 0 in the same cycle so the strobe can coincide with it
  always_comb begin
    phase  = clr ? '0 : cnt;
    strobe = en && (phase == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (phase == DIV_W'(CE_DIV - 1)) ? '0 : phase + DIV_W'(1);
    end else if (clr) begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/srl_test_sequencer.sv
// Run controller for a bank of srl_init_tester instances: drives their rst/ce,
// samples their error bits and reports a sticky per-unit verdict.
module srl_test_sequencer
  import srl_test_pkg::*;
#(
  parameter int unsigned NUM_UNITS    = 4,
  parameter int unsigned CE_DIV       = 1,
  parameter int unsigned RST_CYCLES   = 8,
  parameter int unsigned WARMUP       = 2,
  parameter int unsigned TEST_STROBES = 256,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 tst_rst,
  output logic                 tst_ce,
  input  logic [NUM_UNITS-1:0] tst_error,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_UNITS-1:0] err_flags,
  output logic [CNT_W-1:0]     err_count
);

  localparam int unsigned TOTAL = WARMUP + TEST_STROBES;
  localparam int unsigned STB_W = $clog2(TOTAL + 1);
  localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned PC_W  = $clog2(NUM_UNITS + 1);

  state_t state, next_state;

  logic [RST_W-1:0]     rst_cnt;
  logic [STB_W-1:0]     stb_cnt;
  logic                 strobe, pre_en, pre_clr, launch, rst_done;
  logic                 sample_en;
  logic                 ce_d, tst_rst_d, busy_d, done_d, pass_d;
  logic [NUM_UNITS-1:0] flags_d;
  logic [CNT_W-1:0]     count_d;
  logic [CNT_W:0]       sum;
  logic [PC_W-1:0]      pc;

  assign launch   = start && (state == S_IDLE || state == S_DONE);
  assign rst_done = (state == S_RESET) && (rst_cnt == RST_W'(RST_CYCLES - 1));
  assign pre_clr  = (state == S_RESET);
  assign pre_en   = rst_done || (state == S_WARM) || (state == S_RUN);

  ce_prescaler #(.CE_DIV(CE_DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr    (pre_clr),
    .en     (pre_en),
    .strobe (strobe)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Each strobe decides the phase of the cycle it is issued in; the strobe
  // after the last test strobe's period closes the run.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) next_state = S_RESET;
      S_RESET, S_WARM, S_RUN: begin
        if (strobe) begin
          if (32'(stb_cnt) < WARMUP)     next_state = S_WARM;
          else if (32'(stb_cnt) < TOTAL) next_state = S_RUN;
          else                           next_state = S_DRAIN;
        end
      end
      S_DRAIN: next_state = S_DONE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    pc      = PC_W'(popcount(MAX_UNITS'(tst_error)));
    sum     = {1'b0, err_count} + (CNT_W + 1)'(pc);
    flags_d = err_flags;
    count_d = err_count;
    if (launch) begin
      flags_d = '0;
      count_d = '0;
    end else if (sample_en) begin
      flags_d = err_flags | tst_error;
      count_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
    ce_d      = strobe && (next_state == S_WARM || next_state == S_RUN);
    tst_rst_d = next_state inside {S_IDLE, S_RESET, S_DONE};
    busy_d    = next_state inside {S_RESET, S_WARM, S_RUN, S_DRAIN};
    done_d    = (next_state == S_DONE);
    pass_d    = done_d && (flags_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_cnt <= '0;
      stb_cnt <= '0;
    end else begin
      rst_cnt <= (state == S_RESET) ? rst_cnt + RST_W'(1) : '0;
      if (ce_d)                                      stb_cnt <= stb_cnt + STB_W'(1);
      else if (state != S_WARM && state != S_RUN)    stb_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tst_rst   <= 1'b1;
      tst_ce    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_flags <= '0;
      err_count <= '0;
      sample_en <= 1'b0;
    end else begin
      tst_rst   <= tst_rst_d;
      tst_ce    <= ce_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err_flags <= flags_d;
      err_count <= count_d;
      sample_en <= tst_ce && (state == S_RUN);
    end
  end

endmodule

// File: tb/tb_srl_test_sequencer.sv
// Directed bench for srl_test_sequencer: two configurations, a tester model
// that answers each ce with a registered error, and a per-run scoreboard.
module tb_srl_test_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic sel;
  logic start_drv;
  logic [3:0] err_drv;

  logic start1, tst_rst1, tst_ce1, busy1, done1, pass1;
  logic [3:0] err1, flags1;
  logic [15:0] cnt1;
  logic start2, tst_rst2, tst_ce2, busy2, done2, pass2;
  logic [3:0] err2, flags2;
  logic [3:0] cnt2;

  srl_test_sequencer #(
    .NUM_UNITS(4), .CE_DIV(1), .RST_CYCLES(8), .WARMUP(2), .TEST_STROBES(256), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start1), .tst_rst(tst_rst1), .tst_ce(tst_ce1),
    .tst_error(err1), .busy(busy1), .done(done1), .pass(pass1),
    .err_flags(flags1), .err_count(cnt1)
  );

  srl_test_sequencer #(
    .NUM_UNITS(4), .CE_DIV(4), .RST_CYCLES(3), .WARMUP(2), .TEST_STROBES(8), .CNT_W(4)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .tst_rst(tst_rst2), .tst_ce(tst_ce2),
    .tst_error(err2), .busy(busy2), .done(done2), .pass(pass2),
    .err_flags(flags2), .err_count(cnt2)
  );

  logic o_ce, o_rst, o_busy, o_done, o_pass;
  logic [3:0] o_flags;
  logic [15:0] o_cnt;

  always_comb begin
    start1  = sel ? 1'b0 : start_drv;
    start2  = sel ? start_drv : 1'b0;
    err1    = sel ? 4'h0 : err_drv;
    err2    = sel ? err_drv : 4'h0;
    o_ce    = sel ? tst_ce2 : tst_ce1;
    o_rst   = sel ? tst_rst2 : tst_rst1;
    o_busy  = sel ? busy2 : busy1;
    o_done  = sel ? done2 : done1;
    o_pass  = sel ? pass2 : pass1;
    o_flags = sel ? flags2 : flags1;
    o_cnt   = sel ? {12'h000, cnt2} : cnt1;
  end

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  flags;
    logic [15:0] count;
    logic        pass;
  } exp_t;
  exp_t sb[$];

  int unsigned w_cfg, ts_cfg, div_cfg, cmax_cfg, rcyc_cfg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Error pattern a tester returns for ce pulse number i (1-based) of a run.
  function automatic logic [3:0] pattern(input int mode, input int unsigned i,
                                         input int unsigned w, input int unsigned total);
    case (mode)
      1:       return (i == w + 10) ? 4'b0100 : 4'h0;
      2:       return (i <= w) ? 4'hF : 4'h0;
      3:       return (i == total) ? 4'hF : 4'h0;
      4:       return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic exp_t predict(input int mode, input int unsigned w,
                                   input int unsigned ts, input int unsigned cmax);
    exp_t e;
    int unsigned c;
    logic [3:0] p;
    e.flags = 4'h0;
    c = 0;
    for (int unsigned i = 1; i <= w + ts; i++) begin
      p = pattern(mode, i, w, w + ts);
      if (i > w) begin
        e.flags = e.flags | p;
        c = c + $countones(p);
        if (c > cmax) c = cmax;
      end
    end
    e.count = 16'(c);
    e.pass  = (e.flags == 4'h0);
    return e;
  endfunction

  task automatic run(input string name, input int mode, input bit mid_start);
    int unsigned ce_n, busy_n, rsthi_n, gap_bad, since, cyc;
    logic [3:0] nxt;
    bit fin;
    exp_t e;
    ce_n = 0; busy_n = 0; rsthi_n = 0; gap_bad = 0; since = 0; cyc = 0;
    nxt = 4'h0;
    fin = 1'b0;
    sb.push_back(predict(mode, w_cfg, ts_cfg, cmax_cfg));
    @(negedge clk); start_drv = 1'b1;
    @(negedge clk); start_drv = 1'b0;
    check($sformatf("%s.start_clears", name), {8'h0, o_busy, o_done, o_pass, 1'b0, o_flags, o_cnt},
          {8'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000});
    while (!fin && cyc < 3000) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      err_drv   = nxt;
      nxt       = 4'h0;
      start_drv = 1'b0;
      if (o_done) begin
        fin = 1'b1;
      end else begin
        if (o_busy) busy_n++;
        if (o_busy && o_rst) rsthi_n++;
        since++;
        if (o_ce) begin
          ce_n++;
          if (ce_n > 1 && since != div_cfg) gap_bad++;
          since = 0;
          nxt = pattern(mode, ce_n, w_cfg, w_cfg + ts_cfg);
          if (mid_start && ce_n == 100) start_drv = 1'b1;
        end
      end
    end
    err_drv   = 4'h0;
    start_drv = 1'b0;
    check($sformatf("%s.done_reached", name), 32'(fin), 32'd1);
    e = sb.pop_front();
    check($sformatf("%s.err_flags", name), 32'(o_flags), 32'(e.flags));
    check($sformatf("%s.err_count", name), 32'(o_cnt), 32'(e.count));
    check($sformatf("%s.pass", name), 32'(o_pass), 32'(e.pass));
    check($sformatf("%s.ce_pulses", name), ce_n, w_cfg + ts_cfg);
    check($sformatf("%s.busy_cycles", name), busy_n, rcyc_cfg + (w_cfg + ts_cfg) * div_cfg + 1);
    check($sformatf("%s.rst_cycles", name), rsthi_n, rcyc_cfg);
    check($sformatf("%s.ce_gaps", name), gap_bad, 32'd0);
    check($sformatf("%s.done_outputs", name), {30'h0, o_rst, o_ce}, {30'h0, 1'b1, 1'b0});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; start_drv = 1'b0; err_drv = 4'h0; rst = 1'b1;
    w_cfg = 2; ts_cfg = 256; div_cfg = 1; cmax_cfg = 65535; rcyc_cfg = 8;
    repeat (3) @(negedge clk);
    check("reset.dut1", {16'h0, tst_rst1, tst_ce1, busy1, done1, pass1, 3'h0, flags1, 4'h0},
          {16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'h0, 4'h0, 4'h0});
    check("reset.dut1_count", 32'(cnt1), 32'd0);
    check("reset.dut2", {16'h0, tst_rst2, tst_ce2, busy2, done2, pass2, 3'h0, flags2, cnt2},
          {16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'h0, 4'h0, 4'h0});
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run("clean", 0, 1'b0);
    run("single_fault", 1, 1'b0);
    run("warm_mask", 2, 1'b0);
    run("last_sample", 3, 1'b0);
    run("start_mid_run", 0, 1'b1);

    // Async abort in the middle of a faulty run.
    @(negedge clk); start_drv = 1'b1;
    @(negedge clk); start_drv = 1'b0;
    repeat (30) @(negedge clk);
    err_drv = 4'hF;
    repeat (5) @(negedge clk);
    check("abort.pre_flags", 32'(o_flags), 32'hF);
    #2 rst = 1'b1;
    #1;
    check("abort.outputs", {16'h0, o_rst, o_ce, o_busy, o_done, o_pass, 3'h0, o_flags, 4'h0},
          {16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'h0, 4'h0, 4'h0});
    check("abort.count", 32'(o_cnt), 32'd0);
    err_drv = 4'h0;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort.stays_idle", {30'h0, o_busy, o_rst}, {30'h0, 1'b0, 1'b1});

    sel = 1'b1;
    w_cfg = 2; ts_cfg = 8; div_cfg = 4; cmax_cfg = 15; rcyc_cfg = 3;
    @(negedge clk);
    run("div4_saturate", 4, 1'b0);
    run("div4_clean", 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
